instr_loader: RTL and testbench

- Writer side of the instruction memory: accepts a byte stream (length header, program words, checksum) and issues word writes into a writable instruction RAM.
- The fetch stage reads that RAM by PC; this block fills it before execution.
- Asserts cpu_hold while loading, so the pipeline cannot fetch partially written code.

---
 rtl/instr_loader.sv | 173 +++++++++++++++++
 tb/tb_instr_loader.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
`default_nettype none
// ============================================================================
// Module      : instr_loader
// Description : Writer side of the instruction RAM. Consumes a byte stream of
//               the form  LEN_HI, LEN_LO, {WORD_HI, WORD_LO} x N, CHECKSUM
//               and issues one RAM word write per received word. The fetch
//               stage is held off (cpu_hold) for the whole load so it never
//               sees partially written code.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               start              - pulse; begins a load from IDLE/DONE/ERR
//               byte_in/byte_valid - stream data, handshaked with byte_ready
//               wr_en/wr_addr/wr_data - one-cycle instruction RAM write
//               cpu_hold           - high while a load is in progress
//               done / error       - sticky load result flags
//               word_count         - words written in current/last load
// Revision    : 1.0 - initial release
// ============================================================================
module instr_loader #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] word_count
);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_len_hi  = 3'd1;
    localparam logic [2:0] c_st_len_lo  = 3'd2;
    localparam logic [2:0] c_st_data_hi = 3'd3;
    localparam logic [2:0] c_st_data_lo = 3'd4;
    localparam logic [2:0] c_st_check   = 3'd5;
    localparam logic [2:0] c_st_done    = 3'd6;
    localparam logic [2:0] c_st_err     = 3'd7;

    // One extra bit so a 16-bit header can be compared against DEPTH safely.
    localparam logic [16:0] c_depth_ext = 17'(DEPTH);

    logic [2:0]        r_state;
    logic              r_busy;
    logic [15:0]       r_len;
    logic [7:0]        r_csum;
    logic [7:0]        r_hi;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [15:0]       r_wr_data;
    logic              r_done;
    logic              r_error;
    logic [ADDR_W-1:0] r_word_count;

    logic              w_accept;
    logic [15:0]       w_len;
    logic [ADDR_W-1:0] w_count_inc;

    // r_busy is high exactly in LEN_HI..CHECK; it is maintained alongside
    // every state transition so the ready/hold outputs come straight from a
    // flop rather than a state decode.
    assign byte_ready  = r_busy;
    assign cpu_hold    = r_busy;
    assign wr_en       = r_wr_en;
    assign wr_addr     = r_wr_addr;
    assign wr_data     = r_wr_data;
    assign done        = r_done;
    assign error       = r_error;
    assign word_count  = r_word_count;

    assign w_accept    = byte_valid & r_busy;
    // Full length as seen while the low header byte is on the bus.
    assign w_len       = {r_len[15:8], byte_in};
    assign w_count_inc = r_word_count + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_busy       <= 1'b0;
            r_len        <= '0;
            r_csum       <= '0;
            r_hi         <= '0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_word_count <= '0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                c_st_idle, c_st_done, c_st_err: begin
                    if (start) begin
                        r_state      <= c_st_len_hi;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_error      <= 1'b0;
                        r_word_count <= '0;
                        r_csum       <= '0;
                    end
                end
                c_st_len_hi: begin
                    if (w_accept) begin
                        r_len[15:8] <= byte_in;
                        r_csum      <= r_csum ^ byte_in;
                        r_state     <= c_st_len_lo;
                    end
                end
                c_st_len_lo: begin
                    if (w_accept) begin
                        r_len[7:0] <= byte_in;
                        r_csum     <= r_csum ^ byte_in;
                        if ({1'b0, w_len} > c_depth_ext) begin
                            r_state <= c_st_err;
                            r_error <= 1'b1;
                            r_busy  <= 1'b0;
                        end else if (w_len == 16'd0) begin
                            r_state <= c_st_check;
                        end else begin
                            r_state <= c_st_data_hi;
                        end
                    end
                end
                c_st_data_hi: begin
                    if (w_accept) begin
                        r_hi    <= byte_in;
                        r_csum  <= r_csum ^ byte_in;
                        r_state <= c_st_data_lo;
                    end
                end
                c_st_data_lo: begin
                    if (w_accept) begin
                        r_wr_en      <= 1'b1;
                        r_wr_addr    <= r_word_count;
                        r_wr_data    <= {r_hi, byte_in};
                        r_word_count <= w_count_inc;
                        r_csum       <= r_csum ^ byte_in;
                        // Length was bounded by DEPTH, so it fits in ADDR_W.
                        if (w_count_inc == ADDR_W'(r_len)) begin
                            r_state <= c_st_check;
                        end else begin
                            r_state <= c_st_data_hi;
                        end
                    end
                end
                c_st_check: begin
                    if (w_accept) begin
                        r_busy <= 1'b0;
                        if (byte_in == r_csum) begin
                            r_state <= c_st_done;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= c_st_err;
                            r_error <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_loader
// Description : Self-checking bench for instr_loader. Streams are parsed by a
//               byte-level reference model that derives the expected writes,
//               consumed-byte count and final flags.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_loader;

    localparam int DEPTH  = 256;
    localparam int ADDR_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;
    logic              cpu_hold;
    logic              done;
    logic              error;
    logic [ADDR_W-1:0] word_count;

    instr_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observed writes
    int          got_cyc[$];
    int          got_addr[$];
    logic [15:0] got_data[$];

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            got_cyc.push_back(cyc);
            got_addr.push_back(int'(wr_addr));
            got_data.push_back(wr_data);
        end
    end

    // Expected writes from the reference model
    int          exp_addr[$];
    logic [15:0] exp_data[$];
    int          exp_lo_idx[$];

    int          hs_cyc[0:1023];
    logic [7:0]  stream[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Parse the first lim bytes of a stream the way the loader should.
    task automatic model(input logic [7:0] q[$], input int lim,
                         output int cons, output bit d, output bit e, output int wc);
        int   n;
        logic [7:0] x;
        cons = 0; d = 0; e = 0; wc = 0;
        exp_addr.delete(); exp_data.delete(); exp_lo_idx.delete();
        if (lim < 2) begin cons = lim; return; end
        n = int'(q[0]) * 256 + int'(q[1]);
        cons = 2;
        if (n > DEPTH) begin e = 1; return; end
        x = q[0] ^ q[1];
        for (int k = 0; k < n; k++) begin
            if (3 + 2 * k >= lim) begin cons = lim; return; end
            exp_addr.push_back(k);
            exp_data.push_back({q[2 + 2 * k], q[3 + 2 * k]});
            exp_lo_idx.push_back(3 + 2 * k);
            x = x ^ q[2 + 2 * k] ^ q[3 + 2 * k];
            wc = k + 1;
            cons = 4 + 2 * k;
        end
        if (2 + 2 * n < lim) begin
            cons = 3 + 2 * n;
            if (q[2 + 2 * n] == x) d = 1; else e = 1;
        end
    endtask

    task automatic build_stream(input int n, input bit bad);
        logic [7:0] x;
        logic [7:0] b;
        stream.delete();
        b = 8'(n >> 8); stream.push_back(b); x = b;
        b = 8'(n);      stream.push_back(b); x = x ^ b;
        for (int k = 0; k < 2 * n; k++) begin
            b = 8'($urandom);
            stream.push_back(b);
            x = x ^ b;
        end
        if (bad) x = x ^ 8'(1 << $urandom_range(0, 7));
        stream.push_back(x);
    endtask

    task automatic compare_writes();
        int m;
        check("n_writes", got_addr.size(), exp_addr.size());
        m = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
        for (int k = 0; k < m; k++) begin
            check("wr_addr", got_addr[k], exp_addr[k]);
            check("wr_data", {16'h0, got_data[k]}, {16'h0, exp_data[k]});
            check("wr_latency", got_cyc[k], hs_cyc[exp_lo_idx[k]]);
        end
    endtask

    task automatic run_load(input logic [7:0] q[$], input int lim, input int mid_start, input bit gaps);
        int cons_m, wc_m, cons, tries;
        bit d_m, e_m;
        model(q, lim, cons_m, d_m, e_m, wc_m);
        got_cyc.delete(); got_addr.delete(); got_data.delete();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("hold_after_start", cpu_hold, 1);
        check("ready_after_start", byte_ready, 1);
        cons = 0;
        for (int i = 0; i < lim; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    byte_valid = 1'b0; byte_in = 8'($urandom);
                    @(negedge clk);
                end
            end
            byte_valid = 1'b1; byte_in = q[i];
            start = (i == mid_start) && byte_ready;
            tries = 0;
            while (!byte_ready && tries < 4) begin @(negedge clk); tries++; end
            if (!byte_ready) begin start = 1'b0; break; end
            check("hold_in_load", cpu_hold, 1);
            @(negedge clk);
            hs_cyc[i] = cyc;
            start = 1'b0;
            cons++;
        end
        byte_valid = 1'b0;
        check("consumed", cons, cons_m);
        if (lim == q.size()) begin
            check("done", done, d_m);
            check("error", error, e_m);
            check("word_count", word_count, wc_m);
            check("hold_released", cpu_hold, 0);
            check("ready_released", byte_ready, 0);
            @(negedge clk);
            compare_writes();
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; byte_valid = 1'b1; byte_in = 8'hA5;
        repeat (2) @(negedge clk);
        check("rst_byte_ready", byte_ready, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_cpu_hold", cpu_hold, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_word_count", word_count, 0);
        rst = 1'b0; start = 1'b0; byte_valid = 1'b0;
        @(negedge clk);
        check("idle_ready", byte_ready, 0);

        // Nominal load, back-to-back
        stream = '{8'h00, 8'h02, 8'h96, 8'h02, 8'h12, 8'h34, 8'hB0};
        run_load(stream, stream.size(), -1, 1'b0);
        check("nom_done", done, 1);
        check("nom_data0", got_data.size() > 0 ? {16'h0, got_data[0]} : 32'hx, 32'h9602);
        check("nom_data1", got_data.size() > 1 ? {16'h0, got_data[1]} : 32'hx, 32'h1234);
        check("nom_addr1", got_addr.size() > 1 ? got_addr[1] : 32'hx, 1);

        // Bad checksum
        stream = '{8'h00, 8'h02, 8'h96, 8'h02, 8'h12, 8'h34, 8'hB1};
        run_load(stream, stream.size(), -1, 1'b0);
        check("bad_error", error, 1);
        check("bad_done", done, 0);

        // Length over DEPTH
        stream = '{8'h01, 8'h01, 8'h11, 8'h22, 8'h33};
        run_load(stream, stream.size(), -1, 1'b0);
        check("over_error", error, 1);

        // Nominal with 3-cycle stalls between bytes
        stream = '{8'h00, 8'h02, 8'h96, 8'h02, 8'h12, 8'h34, 8'hB0};
        got_cyc.delete(); got_addr.delete(); got_data.delete();
        begin
            int cons_m, wc_m; bit d_m, e_m;
            model(stream, stream.size(), cons_m, d_m, e_m, wc_m);
            @(negedge clk); start = 1'b1;
            @(negedge clk); start = 1'b0;
            for (int i = 0; i < stream.size(); i++) begin
                byte_valid = 1'b0;
                repeat (3) @(negedge clk);
                check("stall_hold", cpu_hold, 1);
                byte_valid = 1'b1; byte_in = stream[i];
                @(negedge clk);
                hs_cyc[i] = cyc;
            end
            byte_valid = 1'b0;
            check("stall_done", done, 1);
            check("stall_count", word_count, 2);
            @(negedge clk);
            compare_writes();
        end

        // Zero length
        stream = '{8'h00, 8'h00, 8'h00};
        run_load(stream, stream.size(), -1, 1'b0);
        check("zero_done", done, 1);

        // Abort a 3-word load after its first write
        build_stream(3, 1'b0);
        run_load(stream, 4, -1, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_hold", cpu_hold, 0);
        check("abort_done", done, 0);
        check("abort_error", error, 0);
        check("abort_ready", byte_ready, 0);
        check("abort_wr_en", wr_en, 0);
        compare_writes();

        // Restart with a start pulse mid-load
        build_stream(3, 1'b0);
        run_load(stream, stream.size(), 4, 1'b0);
        check("restart_done", done, 1);

        // Randomized loads
        for (int t = 0; t < 8; t++) begin
            int n, ms;
            n = int'($urandom_range(1, 12));
            build_stream(n, $urandom_range(0, 3) == 0);
            ms = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, stream.size() - 1)) : -1;
            run_load(stream, stream.size(), ms, $urandom_range(0, 1) == 1);
        end

        // Boundary: N == DEPTH
        build_stream(DEPTH, 1'b0);
        run_load(stream, stream.size(), -1, 1'b0);
        check("full_last_addr", got_addr.size() > 0 ? got_addr[got_addr.size() - 1] : -1, DEPTH - 1);

        // Random over-length header
        begin
            int n;
            n = int'($urandom_range(DEPTH + 1, 65535));
            stream.delete();
            stream.push_back(8'(n >> 8));
            stream.push_back(8'(n));
            repeat (4) stream.push_back(8'($urandom));
            run_load(stream, stream.size(), -1, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
